// File: rtl/affine_addr_gen.sv
// N-dimensional affine address generator: walks a nested loop of NDIM counters
// (dim 0 innermost) and emits one address per accepted beat on a valid/ready stream.
module affine_addr_gen #(
  parameter int NDIM = 3,
  parameter int AW   = 32,
  parameter int CW   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [AW-1:0]      cfg_base,
  input  logic [NDIM*CW-1:0] cfg_extent,
  input  logic [NDIM*AW-1:0] cfg_delta,
  output logic [AW-1:0]      addr,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic               last,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     done_q, done_d;
  logic [NDIM-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [NDIM-1:0][CW-1:0]  lim_q, lim_d;      // extent-1, with extent 0 folded to 1
  logic [NDIM-1:0][AW-1:0]  delta_q, delta_d;

  logic [NDIM-1:0][CW-1:0]  cfg_lim;
  logic                     start_last;
  logic [NDIM-1:0][CW-1:0]  cnt_step;
  logic [AW-1:0]            step_delta;
  logic                     step_last;
  logic                     found;

  always_comb begin
    start_last = 1'b1;
    for (int d = 0; d < NDIM; d++) begin
      cfg_lim[d] = (cfg_extent[d*CW +: CW] == '0) ? '0 : cfg_extent[d*CW +: CW] - CW'(1);
      if (cfg_lim[d] != '0) start_last = 1'b0;
    end
  end

  // Odometer step: lowest non-saturated dim advances, all dims below it roll to 0.
  always_comb begin
    found      = 1'b0;
    step_delta = '0;
    cnt_step   = cnt_q;
    step_last  = 1'b1;
    for (int d = 0; d < NDIM; d++) begin
      if (!found) begin
        if (cnt_q[d] < lim_q[d]) begin
          found       = 1'b1;
          cnt_step[d] = cnt_q[d] + CW'(1);
          step_delta  = delta_q[d];
        end else begin
          cnt_step[d] = '0;
        end
      end
    end
    for (int d = 0; d < NDIM; d++) begin
      if (cnt_step[d] != lim_q[d]) step_last = 1'b0;
    end
  end

  // NOTE: every signal gets its hold/default value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    delta_d = delta_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lim_d   = cfg_lim;
          delta_d = cfg_delta;
          cnt_d   = '0;
          addr_d  = cfg_base;
          valid_d = 1'b1;
          last_d  = start_last;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end else if (valid_q && addr_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_step;
            addr_d = addr_q + step_delta;
            last_d = step_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      lim_q   <= '0;
      delta_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      delta_q <= delta_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign last       = last_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;

endmodule

// File: tb/tb_affine_addr_gen.sv
// Self-checking bench for affine_addr_gen: directed and randomized walks checked
// against a closed-form address model (beat index -> per-dim advance counts).
module tb_affine_addr_gen;
  localparam int NDIM = 3;
  localparam int AW   = 32;
  localparam int CW   = 16;

  logic              clk = 1'b0;
  logic              rst_n, start, abort, addr_ready;
  logic [AW-1:0]     cfg_base, addr;
  logic [NDIM*CW-1:0] cfg_extent;
  logic [NDIM*AW-1:0] cfg_delta;
  logic              addr_valid, last, busy, done;

  int checks = 0;
  int errors = 0;

  logic [31:0] cur_base;
  int          cur_ext [3];
  logic [31:0] cur_dl  [3];

  affine_addr_gen #(.NDIM(NDIM), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_extent(cfg_extent), .cfg_delta(cfg_delta),
    .addr(addr), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int e);
    return (e == 0) ? 1 : e;
  endfunction

  function automatic int model_total();
    return eff(cur_ext[0]) * eff(cur_ext[1]) * eff(cur_ext[2]);
  endfunction

  // Beat i has advanced dim d exactly floor(i/P_d) - floor(i/P_{d+1}) times,
  // where P_d is the product of the extents of all dims inside d.
  function automatic logic [31:0] model_addr(input int i);
    int p [4];
    logic [31:0] a;
    p[0] = 1;
    for (int d = 0; d < 3; d++) p[d+1] = p[d] * eff(cur_ext[d]);
    a = cur_base;
    for (int d = 0; d < 3; d++) a = a + cur_dl[d] * 32'(i / p[d] - i / p[d+1]);
    return a;
  endfunction

  task automatic set_cfg(input logic [31:0] base, input int e0, input int e1, input int e2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    cur_base = base;
    cur_ext[0] = e0; cur_ext[1] = e1; cur_ext[2] = e2;
    cur_dl[0] = d0;  cur_dl[1] = d1;  cur_dl[2] = d2;
    cfg_base   = base;
    cfg_extent = {16'(e2), 16'(e1), 16'(e0)};
    cfg_delta  = {d2, d1, d0};
  endtask

  // Starts at a negedge and ends on the negedge where done is expected high.
  // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: random ready.
  task automatic run_walk(input logic [31:0] base, input int e0, input int e1, input int e2,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                          input int mode, input bit with_abort);
    int total, beat, cyc;
    bit hold, r;
    logic [31:0] held_addr;
    logic held_last;
    set_cfg(base, e0, e1, e2, d0, d1, d2);
    start = 1'b1; abort = with_abort; addr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("done_clear", done, 0);
    check("busy_start", busy, 1);
    total = model_total();
    beat = 0; cyc = 0; hold = 0;
    held_addr = '0; held_last = 1'b0;
    while (beat < total && cyc < total * 4 + 20) begin
      check("valid_run", addr_valid, 1);
      if (hold) begin
        check("addr_hold", addr, held_addr);
        check("last_hold", last, held_last);
      end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      addr_ready = r;
      if (r) begin
        check($sformatf("addr_beat%0d", beat), addr, model_addr(beat));
        check($sformatf("last_beat%0d", beat), last, beat == total - 1);
        beat++;
        hold = 0;
      end else begin
        hold = 1;
        held_addr = addr;
        held_last = last;
      end
      cfg_base   = $urandom;
      cfg_extent = 48'({$urandom, $urandom});
      cfg_delta  = {$urandom, $urandom, $urandom};
      start      = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; addr_ready = 1'b0;
    check("beats_in_budget", beat, total);
    check("done_pulse", done, 1);
    check("valid_end", addr_valid, 0);
    check("busy_end", busy, 0);
    check("last_end", last, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
    cfg_base = '0; cfg_extent = '0; cfg_delta = '0;
    #1;
    check("rst_addr", addr, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_valid", addr_valid, 0);

    run_walk(32'h100, 3, 2, 1, 32'h4, 32'h38, 32'h0, 0, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);

    run_walk(32'h100, 3, 2, 1, 32'h4, 32'h38, 32'h0, 1, 0);
    // Back-to-back: start issued in the cycle done is high.
    run_walk(32'h1234, 0, 0, 0, 32'h10, 32'h20, 32'h30, 0, 0);
    @(negedge clk);
    run_walk(32'hFFFF_FFFC, 3, 1, 1, 32'h4, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    run_walk(32'h800, 2, 2, 2, 32'h1, 32'hE, 32'hFFFF_FFE0, 2, 1);
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      run_walk($urandom, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom, $urandom, $urandom, 2, 0);
      @(negedge clk);
    end

    // Abort during the third beat of a 3x3 walk; abort wins over the accept.
    set_cfg(32'h2000, 3, 3, 1, 32'h8, 32'h40, 32'h0);
    start = 1'b1;
    @(negedge clk); start = 1'b0; addr_ready = 1'b1;
    check("ab_beat0", addr, model_addr(0));
    @(negedge clk);
    check("ab_beat1", addr, model_addr(1));
    @(negedge clk);
    check("ab_beat2", addr, model_addr(2));
    abort = 1'b1;
    @(negedge clk); abort = 1'b0; addr_ready = 1'b0;
    check("ab_valid", addr_valid, 0);
    check("ab_busy", busy, 0);
    check("ab_last", last, 0);
    check("ab_done", done, 0);
    @(negedge clk);
    check("ab_done_later", done, 0);
    run_walk(32'h2000, 3, 3, 1, 32'h8, 32'h40, 32'h0, 0, 0);
    @(negedge clk);

    // Asynchronous reset mid-walk, checked before any clock edge.
    set_cfg(32'h3000, 4, 4, 1, 32'h4, 32'h10, 32'h0);
    start = 1'b1;
    @(negedge clk); start = 1'b0; addr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", addr, 0);
    check("arst_valid", addr_valid, 0);
    check("arst_last", last, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk); rst_n = 1'b1; addr_ready = 1'b0;
    @(negedge clk);
    check("arst_no_done", done, 0);
    run_walk(32'h4000, 2, 3, 2, 32'h4, 32'h8, 32'h100, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
